// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the pipeline
// writeback stage and a coprocessor. Pipeline writes have priority. Coprocessor
// results wait in a small FIFO and drain in idle writeback slots, or in a forced
// one-cycle pipeline stall once the FIFO has been blocked for STARVE_MAX cycles.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pipe_regwrite/memtoreg   MEM/WB write enable and data select
//   pipe_rd                  MEM/WB destination register
//   pipe_read_data/result    load data / ALU result
//   cop_valid/rd/data        coprocessor result (pushed when cop_ready)
//   cop_ready                FIFO has space (from registered count)
//   stall_pipe               freeze IF..MEM/WB this cycle (forced drain)
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
module wb_port_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_regwrite,
  input  logic        pipe_memtoreg,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_read_data,
  input  logic [31:0] pipe_result,
  input  logic        cop_valid,
  input  logic [4:0]  cop_rd,
  input  logic [31:0] cop_data,
  output logic        cop_ready,
  output logic        stall_pipe,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [0:0] ST_PIPE  = 1'b0;
  localparam logic [0:0] ST_FORCE = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve;
  logic [STV_W-1:0] starve_nxt;
  logic [DEPTH-1:0] ent_vld;
  logic [4:0]       ent_rd   [DEPTH];
  logic [31:0]      ent_data [DEPTH];

  logic             pipe_req;
  logic [31:0]      pipe_wdata;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             pipe_wr;
  logic [DEPTH-1:0] squash;
  logic             we_nxt;
  logic [4:0]       waddr_nxt;
  logic [31:0]      wdata_nxt;

  assign pipe_req   = pipe_regwrite & (pipe_rd != 5'd0);
  assign pipe_wdata = pipe_memtoreg ? pipe_read_data : pipe_result;
  assign fifo_empty = (count == CNT_W'(0));
  // Depends only on registered count: a same-cycle pop never frees a slot early.
  assign cop_ready  = (count != CNT_W'(DEPTH));
  assign stall_pipe = (state == ST_FORCE);
  assign push       = cop_valid & cop_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_PIPE;
    else     state <= state_nxt;
  end

  // Next-state, port selection and starvation accounting
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve;
    pop        = 1'b0;
    pipe_wr    = 1'b0;
    we_nxt     = 1'b0;
    waddr_nxt  = 5'd0;
    wdata_nxt  = 32'd0;
    case (state)
      ST_FORCE: begin
        pop        = !fifo_empty;
        starve_nxt = STV_W'(0);
        state_nxt  = ST_PIPE;
      end
      default: begin
        if (pipe_req) begin
          pipe_wr   = 1'b1;
          we_nxt    = 1'b1;
          waddr_nxt = pipe_rd;
          wdata_nxt = pipe_wdata;
          if (fifo_empty) begin
            starve_nxt = STV_W'(0);
          end else if (starve == STV_W'(STARVE_MAX - 1)) begin
            starve_nxt = STV_W'(STARVE_MAX);
            state_nxt  = ST_FORCE;
          end else begin
            starve_nxt = starve + STV_W'(1);
          end
        end else begin
          pop        = !fifo_empty;
          starve_nxt = STV_W'(0);
        end
      end
    endcase
    // Squashed or rd=0 heads are popped silently.
    if (pop && ent_vld[rd_ptr] && (ent_rd[rd_ptr] != 5'd0)) begin
      we_nxt    = 1'b1;
      waddr_nxt = ent_rd[rd_ptr];
      wdata_nxt = ent_data[rd_ptr];
    end
  end

  // A pipeline write is younger than every queued entry to the same rd.
  always_comb begin
    squash = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      squash[i] = pipe_wr && (ent_rd[i] == pipe_rd);
    end
  end

  // FIFO control and starve counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= PTR_W'(0);
      rd_ptr  <= PTR_W'(0);
      count   <= CNT_W'(0);
      starve  <= STV_W'(0);
      ent_vld <= '0;
    end else begin
      starve <= starve_nxt;
      count  <= count + CNT_W'(push) - CNT_W'(pop);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      // Squash first; a push only lands in a free slot and overrides it.
      ent_vld <= ent_vld & ~squash;
      if (push) begin
        wr_ptr          <= wr_ptr + PTR_W'(1);
        ent_vld[wr_ptr] <= (cop_rd != 5'd0);
      end
    end
  end

  // FIFO payload storage
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd[wr_ptr]   <= cop_rd;
      ent_data[wr_ptr] <= cop_data;
    end
  end

  // Registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else begin
      rf_we    <= we_nxt;
      rf_waddr <= waddr_nxt;
      rf_wdata <= wdata_nxt;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based model of the arbitration rules.
module tb_wb_port_arbiter;

  localparam int unsigned DEPTH      = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic        clk;
  logic        rst;
  logic        pipe_regwrite;
  logic        pipe_memtoreg;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_read_data;
  logic [31:0] pipe_result;
  logic        cop_valid;
  logic [4:0]  cop_rd;
  logic [31:0] cop_data;
  logic        cop_ready;
  logic        stall_pipe;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .pipe_regwrite(pipe_regwrite), .pipe_memtoreg(pipe_memtoreg),
    .pipe_rd(pipe_rd), .pipe_read_data(pipe_read_data), .pipe_result(pipe_result),
    .cop_valid(cop_valid), .cop_rd(cop_rd), .cop_data(cop_data),
    .cop_ready(cop_ready), .stall_pipe(stall_pipe),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  // Reference model: queued coprocessor results, blocked-cycle count, forced-drain flag.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          vld;
  } ent_t;
  ent_t mq[$];
  int   m_starve;
  bit   m_force;

  logic        obs_ready, obs_stall;
  logic        exp_ready, exp_stall, exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;

  task automatic idle_inputs();
    pipe_regwrite = 1'b0; pipe_memtoreg = 1'b0; pipe_rd = 5'd0;
    pipe_read_data = 32'd0; pipe_result = 32'd0;
    cop_valid = 1'b0; cop_rd = 5'd0; cop_data = 32'd0;
  endtask

  // Advance one clock: sample pre-edge outputs, step the model, sample post-edge.
  task automatic tick();
    ent_t h;
    ent_t e;
    bit   acc;
    obs_ready = cop_ready;
    obs_stall = stall_pipe;
    exp_ready = (mq.size() != DEPTH);
    exp_stall = m_force;
    exp_we = 1'b0; exp_waddr = 5'd0; exp_wdata = 32'd0;
    if (rst) begin
      mq.delete(); m_starve = 0; m_force = 0;
    end else begin
      acc = cop_valid && (mq.size() < DEPTH);
      if (m_force || !(pipe_regwrite && pipe_rd != 5'd0)) begin
        if (mq.size() > 0) begin
          h = mq.pop_front();
          if (h.vld) begin exp_we = 1'b1; exp_waddr = h.rd; exp_wdata = h.data; end
        end
        m_starve = 0; m_force = 0;
      end else begin
        exp_we = 1'b1; exp_waddr = pipe_rd;
        exp_wdata = pipe_memtoreg ? pipe_read_data : pipe_result;
        foreach (mq[i]) if (mq[i].rd == pipe_rd) mq[i].vld = 0;
        if (mq.size() > 0) begin
          m_starve++;
          if (m_starve >= STARVE_MAX) m_force = 1;
        end else begin
          m_starve = 0;
        end
      end
      if (acc) begin
        e.rd = cop_rd; e.data = cop_data; e.vld = (cop_rd != 5'd0);
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if (rf_we !== 1'b0 || cop_ready !== 1'b1 || stall_pipe !== 1'b0)
        $display("FAIL reset_idle cyc%0d: rf_we=%b cop_ready=%b stall_pipe=%b, required 0/1/0",
                 i, rf_we, cop_ready, stall_pipe);
      else n_pass++;
    end
  endtask

  task automatic test_pipe_writes();
    pipe_regwrite = 1'b1; pipe_rd = 5'd5; pipe_memtoreg = 1'b1;
    pipe_read_data = 32'hDEADBEEF; pipe_result = 32'h0BAD0BAD;
    tick();
    n_chk++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF)
      $display("FAIL pipe_load: got we=%b addr=%0d data=%h, required 1/5/deadbeef", rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    pipe_memtoreg = 1'b0; pipe_result = 32'h12;
    tick();
    n_chk++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h12)
      $display("FAIL pipe_alu: got we=%b addr=%0d data=%h, required 1/5/00000012", rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    pipe_rd = 5'd0; pipe_result = 32'h77;
    tick();
    n_chk++;
    if (rf_we !== 1'b0)
      $display("FAIL pipe_rd0: got we=%b addr=%0d, required we=0", rf_we, rf_waddr);
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_cop_drain();
    cop_valid = 1'b1; cop_rd = 5'd7; cop_data = 32'hA5A5A5A5;
    tick();
    n_chk++;
    if (rf_we !== 1'b0)
      $display("FAIL cop_latency1: got we=%b, required 0", rf_we);
    else n_pass++;
    idle_inputs();
    tick();
    n_chk++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hA5A5A5A5)
      $display("FAIL cop_drain: got we=%b addr=%0d data=%h, required 1/7/a5a5a5a5", rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    tick();
    n_chk++;
    if (rf_we !== 1'b0 || cop_ready !== 1'b1)
      $display("FAIL cop_after: got we=%b ready=%b, required 0/1", rf_we, cop_ready);
    else n_pass++;
  endtask

  task automatic test_starvation();
    pipe_regwrite = 1'b1; pipe_rd = 5'd3; pipe_result = 32'h33;
    cop_valid = 1'b1; cop_rd = 5'd9; cop_data = 32'h99;
    tick();
    cop_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (obs_stall !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h33)
        $display("FAIL starve_pipe%0d: stall=%b we=%b addr=%0d, required 0/1/3", i, obs_stall, rf_we, rf_waddr);
      else n_pass++;
    end
    tick();
    n_chk++;
    if (obs_stall !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99)
      $display("FAIL starve_force: stall=%b we=%b addr=%0d data=%h, required 1/1/9/00000099",
               obs_stall, rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    tick();
    n_chk++;
    if (obs_stall !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'd3)
      $display("FAIL starve_resume: stall=%b we=%b addr=%0d, required 0/1/3", obs_stall, rf_we, rf_waddr);
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_back_pressure();
    pipe_regwrite = 1'b1; pipe_rd = 5'd3; pipe_result = 32'h33;
    cop_valid = 1'b1; cop_rd = 5'd10; cop_data = 32'h10;
    tick();
    cop_rd = 5'd11; cop_data = 32'h11;
    tick();
    n_chk++;
    if (cop_ready !== 1'b0)
      $display("FAIL bp_full: cop_ready=%b, required 0", cop_ready);
    else n_pass++;
    pipe_regwrite = 1'b0; pipe_rd = 5'd0;
    cop_rd = 5'd12; cop_data = 32'h12;
    tick();
    n_chk++;
    if (obs_ready !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'h10 || cop_ready !== 1'b1)
      $display("FAIL bp_pop10: ready_before=%b we=%b addr=%0d ready_after=%b, required 0/1/10/1",
               obs_ready, rf_we, rf_waddr, cop_ready);
    else n_pass++;
    tick();
    cop_valid = 1'b0;
    n_chk++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'h11)
      $display("FAIL bp_pop11: we=%b addr=%0d data=%h, required 1/11/00000011", rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    tick();
    n_chk++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'h12)
      $display("FAIL bp_pop12: we=%b addr=%0d data=%h, required 1/12/00000012", rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    idle_inputs();
    tick();
    n_chk++;
    if (rf_we !== 1'b0 || cop_ready !== 1'b1)
      $display("FAIL bp_empty: we=%b ready=%b, required 0/1", rf_we, cop_ready);
    else n_pass++;
  endtask

  task automatic test_squash();
    cop_valid = 1'b1; cop_rd = 5'd4; cop_data = 32'h1;
    tick();
    idle_inputs();
    pipe_regwrite = 1'b1; pipe_rd = 5'd4; pipe_result = 32'h2;
    tick();
    n_chk++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h2)
      $display("FAIL squash_pipe: we=%b addr=%0d data=%h, required 1/4/00000002", rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    idle_inputs();
    tick();
    n_chk++;
    if (rf_we !== 1'b0 || cop_ready !== 1'b1)
      $display("FAIL squash_pop: we=%b addr=%0d ready=%b, required we=0 ready=1", rf_we, rf_waddr, cop_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    pipe_regwrite = 1'b1; pipe_rd = 5'd3; pipe_result = 32'h33;
    cop_valid = 1'b1; cop_rd = 5'd20; cop_data = 32'h20;
    tick();
    cop_rd = 5'd21; cop_data = 32'h21;
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    n_chk++;
    if (rf_we !== 1'b0)
      $display("FAIL rst_mid_cycle: we=%b addr=%0d, required 0", rf_we, rf_waddr);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (rf_we !== 1'b0 || cop_ready !== 1'b1 || stall_pipe !== 1'b0)
        $display("FAIL rst_mid_after%0d: we=%b addr=%0d ready=%b stall=%b, required 0/-/1/0",
                 i, rf_we, rf_waddr, cop_ready, stall_pipe);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!stall_pipe) begin
        pipe_regwrite  = ($urandom_range(0, 9) < 7);
        pipe_memtoreg  = 1'($urandom_range(0, 1));
        pipe_rd        = 5'($urandom_range(0, 7));
        pipe_read_data = $urandom;
        pipe_result    = $urandom;
      end
      cop_valid = ($urandom_range(0, 1) == 1);
      cop_rd    = 5'($urandom_range(0, 7));
      cop_data  = $urandom;
      tick();
      n_chk++;
      if (obs_ready !== exp_ready || obs_stall !== exp_stall)
        $display("FAIL rand_ctrl cyc%0d: ready=%b stall=%b, required %b/%b", c, obs_ready, obs_stall, exp_ready, exp_stall);
      else n_pass++;
      n_chk++;
      if (rf_we !== exp_we || (exp_we && (rf_waddr !== exp_waddr || rf_wdata !== exp_wdata)))
        $display("FAIL rand_write cyc%0d: we=%b addr=%0d data=%h, required %b/%0d/%h",
                 c, rf_we, rf_waddr, rf_wdata, exp_we, exp_waddr, exp_wdata);
      else n_pass++;
    end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    m_starve = 0; m_force = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_pipe_writes();
    test_cop_drain();
    test_starvation();
    test_back_pressure();
    test_squash();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
